// File: rtl/coef_ram_pkg.sv
// Shared defaults and clear-engine state encoding for the Kyber NTT coefficient RAM.
package coef_ram_pkg;

  localparam int unsigned DefDw = 16;
  localparam int unsigned DefAw = 8;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clr_state_e;

endpackage

// File: rtl/coef_ram_dp_if.sv
// Two-port coefficient RAM bus: clear handshake plus independent ports A and B.
interface coef_ram_dp_if #(
  parameter int unsigned DW = coef_ram_pkg::DefDw,
  parameter int unsigned AW = coef_ram_pkg::DefAw
) ();

  logic          clr_req;
  logic          busy;
  logic          a_en;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din;
  logic [DW-1:0] a_dout;
  logic          a_vld;
  logic          b_en;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din;
  logic [DW-1:0] b_dout;
  logic          b_vld;

  modport master (
    output clr_req, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din,
    input  busy, a_dout, a_vld, b_dout, b_vld
  );

  modport slave (
    input  clr_req, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_din,
    output busy, a_dout, a_vld, b_dout, b_vld
  );

endinterface

// File: rtl/tdp_ram_core.sv
// Plain inferred DEPTH x DW true-dual-port array; no reset, read-or-write per port per cycle.
module tdp_ram_core #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) begin
        mem[a_addr] <= a_din;
      end else begin
        a_dout <= mem[a_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (b_en) begin
      if (b_we) begin
        mem[b_addr] <= b_din;
      end else begin
        b_dout <= mem[b_addr];
      end
    end
  end

endmodule

// File: rtl/coef_ram_dp.sv
// Coefficient RAM top: clear engine, port muxing, collision handling, forwarding and read pipeline.
module coef_ram_dp
  import coef_ram_pkg::*;
#(
  parameter int unsigned DW      = DefDw,
  parameter int unsigned AW      = DefAw,
  parameter bit          OUT_REG = 1'b0
) (
  input logic          clk,
  input logic          rst,
  coef_ram_dp_if.slave bus
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned CW    = (AW > 1) ? AW - 1 : 1;
  localparam logic [CW-1:0] CntLast = CW'(Depth / 2 - 1);

  clr_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy, idle;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StIdle;
      end
    endcase
  end

  assign busy     = (state_q == StClear);
  assign idle     = ~busy;
  assign bus.busy = busy;

  // Same-address double write: A wins, so B's write is dropped before the array.
  logic same_addr, a_wr, a_rd, b_wr, b_rd;
  assign same_addr = (bus.a_addr == bus.b_addr);
  assign a_wr      = idle & bus.a_en & bus.a_we;
  assign a_rd      = idle & bus.a_en & ~bus.a_we;
  assign b_wr      = idle & bus.b_en & bus.b_we & ~(a_wr & same_addr);
  assign b_rd      = idle & bus.b_en & ~bus.b_we;

  logic          ca_en, ca_we, cb_en, cb_we;
  logic [AW-1:0] ca_addr, cb_addr;
  logic [DW-1:0] ca_din, cb_din, ca_dout, cb_dout;

  // Array is left untouched while reset is asserted.
  always_comb begin
    ca_en   = rst & (a_wr | a_rd);
    ca_we   = rst & a_wr;
    ca_addr = bus.a_addr;
    ca_din  = bus.a_din;
    cb_en   = rst & (b_wr | b_rd);
    cb_we   = rst & b_wr;
    cb_addr = bus.b_addr;
    cb_din  = bus.b_din;
    if (busy) begin
      ca_en   = rst;
      ca_we   = rst;
      ca_addr = AW'({cnt_q, 1'b0});
      ca_din  = '0;
      cb_en   = rst;
      cb_we   = rst;
      cb_addr = AW'({cnt_q, 1'b1});
      cb_din  = '0;
    end
  end

  tdp_ram_core #(
    .DW (DW),
    .AW (AW)
  ) u_core (
    .clk    (clk),
    .a_en   (ca_en),
    .a_we   (ca_we),
    .a_addr (ca_addr),
    .a_din  (ca_din),
    .a_dout (ca_dout),
    .b_en   (cb_en),
    .b_we   (cb_we),
    .b_addr (cb_addr),
    .b_din  (cb_din),
    .b_dout (cb_dout)
  );

  // Read-during-write across ports: the compare travels with the read, never the array result.
  logic          a_rd_q, b_rd_q, a_fwd_q, b_fwd_q, a_v1_q, b_v1_q;
  logic [DW-1:0] a_fwd_data_q, b_fwd_data_q, a_d1_q, b_d1_q;
  logic [DW-1:0] a_rdata, b_rdata;

  assign a_rdata = a_fwd_q ? a_fwd_data_q : ca_dout;
  assign b_rdata = b_fwd_q ? b_fwd_data_q : cb_dout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_rd_q       <= 1'b0;
      b_rd_q       <= 1'b0;
      a_fwd_q      <= 1'b0;
      b_fwd_q      <= 1'b0;
      a_fwd_data_q <= '0;
      b_fwd_data_q <= '0;
      a_v1_q       <= 1'b0;
      b_v1_q       <= 1'b0;
      a_d1_q       <= '0;
      b_d1_q       <= '0;
    end else begin
      a_rd_q       <= a_rd;
      b_rd_q       <= b_rd;
      a_fwd_q      <= a_rd & b_wr & same_addr;
      b_fwd_q      <= b_rd & a_wr & same_addr;
      a_fwd_data_q <= bus.b_din;
      b_fwd_data_q <= bus.a_din;
      a_v1_q       <= a_rd_q;
      b_v1_q       <= b_rd_q;
      if (a_rd_q) a_d1_q <= a_rdata;
      if (b_rd_q) b_d1_q <= b_rdata;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic          a_v2_q, b_v2_q;
    logic [DW-1:0] a_d2_q, b_d2_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        if (a_v1_q) a_d2_q <= a_d1_q;
        if (b_v1_q) b_d2_q <= b_d1_q;
      end
    end

    assign bus.a_vld  = a_v2_q;
    assign bus.b_vld  = b_v2_q;
    assign bus.a_dout = a_d2_q;
    assign bus.b_dout = b_d2_q;
  end else begin : g_no_out_reg
    assign bus.a_vld  = a_v1_q;
    assign bus.b_vld  = b_v1_q;
    assign bus.a_dout = a_d1_q;
    assign bus.b_dout = b_d1_q;
  end

endmodule

// File: tb/tb_coef_ram_dp.sv
// Bench for coef_ram_dp: OUT_REG=0 and OUT_REG=1 instances share stimulus, checked against a cycle model.
module tb_coef_ram_dp;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned Depth = 256;
  localparam int unsigned Half  = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coef_ram_dp_if #(.DW(DW), .AW(AW)) bus0 ();
  coef_ram_dp_if #(.DW(DW), .AW(AW)) bus1 ();

  assign bus1.clr_req = bus0.clr_req;
  assign bus1.a_en    = bus0.a_en;
  assign bus1.a_we    = bus0.a_we;
  assign bus1.a_addr  = bus0.a_addr;
  assign bus1.a_din   = bus0.a_din;
  assign bus1.b_en    = bus0.b_en;
  assign bus1.b_we    = bus0.b_we;
  assign bus1.b_addr  = bus0.b_addr;
  assign bus1.b_din   = bus0.b_din;

  coef_ram_dp #(.DW(DW), .AW(AW), .OUT_REG(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  coef_ram_dp #(.DW(DW), .AW(AW), .OUT_REG(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Streams: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
  logic [3:0]    obs_vld;
  logic [DW-1:0] obs_dout [4];
  logic [1:0]    obs_busy;
  assign obs_vld     = {bus1.b_vld, bus1.a_vld, bus0.b_vld, bus0.a_vld};
  assign obs_dout[0] = bus0.a_dout;
  assign obs_dout[1] = bus0.b_dout;
  assign obs_dout[2] = bus1.a_dout;
  assign obs_dout[3] = bus1.b_dout;
  assign obs_busy    = {bus1.busy, bus0.busy};

  int checks = 0;
  int errors = 0;

  // Reference model: array contents, remaining clear cycles, and pending read results.
  typedef struct packed {
    int            due;
    logic [1:0]    strm;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mem_m [Depth];
  int            clr_left = 0;
  int            cyc = 0;
  rd_t           pend [$];
  logic [3:0]    exp_vld = '0;
  logic [DW-1:0] exp_dout [4];
  logic          exp_busy = 1'b1;

  task automatic set_idle();
    bus0.clr_req = 1'b0;
    bus0.a_en = 1'b0; bus0.a_we = 1'b0; bus0.a_addr = '0; bus0.a_din = '0;
    bus0.b_en = 1'b0; bus0.b_we = 1'b0; bus0.b_addr = '0; bus0.b_din = '0;
  endtask

  task automatic set_a(input logic en, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] din);
    bus0.a_en = en; bus0.a_we = we; bus0.a_addr = addr; bus0.a_din = din;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] din);
    bus0.b_en = en; bus0.b_we = we; bus0.b_addr = addr; bus0.b_din = din;
  endtask

  task automatic set_random(input bool_narrow);
    logic [AW-1:0] aa, ba;
    aa = bool_narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
    ba = bool_narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
    set_a(1'($urandom_range(0, 3) != 0), 1'($urandom), aa, DW'($urandom));
    set_b(1'($urandom_range(0, 3) != 0), 1'($urandom), ba, DW'($urandom));
  endtask

  // Applies the current inputs to the model as one clock edge, then advances to the next negedge.
  task automatic tick();
    logic [DW-1:0] v;
    int            k;
    if (!rst) begin
      clr_left = Half;
      pend.delete();
      for (int p = 0; p < 4; p++) exp_dout[p] = '0;
    end else if (clr_left > 0) begin
      k = int'(Half) - clr_left;
      mem_m[2*k]   = '0;
      mem_m[2*k+1] = '0;
      clr_left--;
    end else begin
      if (bus0.a_en && !bus0.a_we) begin
        v = (bus0.b_en && bus0.b_we && bus0.b_addr == bus0.a_addr) ? bus0.b_din
                                                                    : mem_m[bus0.a_addr];
        pend.push_back('{due: cyc + 2, strm: 2'd0, data: v});
        pend.push_back('{due: cyc + 3, strm: 2'd2, data: v});
      end
      if (bus0.b_en && !bus0.b_we) begin
        v = (bus0.a_en && bus0.a_we && bus0.a_addr == bus0.b_addr) ? bus0.a_din
                                                                    : mem_m[bus0.b_addr];
        pend.push_back('{due: cyc + 2, strm: 2'd1, data: v});
        pend.push_back('{due: cyc + 3, strm: 2'd3, data: v});
      end
      if (bus0.b_en && bus0.b_we) mem_m[bus0.b_addr] = bus0.b_din;
      if (bus0.a_en && bus0.a_we) mem_m[bus0.a_addr] = bus0.a_din;
      if (bus0.clr_req) clr_left = Half;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_busy = (clr_left > 0);
    exp_vld  = '0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        exp_vld[pend[i].strm]  = 1'b1;
        exp_dout[pend[i].strm] = pend[i].data;
        pend.delete(i);
      end
    end
  endtask

  task automatic test_reset();
    int busy_cnt, zero_cnt;
    set_idle();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (obs_busy !== 2'b11 || obs_vld !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: busy=%b vld=%b required busy=11 vld=0000",
                 cyc, obs_busy, obs_vld);
      end
    end
    rst = 1'b1;
    busy_cnt = 0;
    for (int n = 0; n < 130; n++) begin
      if (bus0.busy === 1'b1) busy_cnt++;
      tick();
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_vld[p] !== exp_vld[p] || obs_dout[p] !== exp_dout[p]) begin
          errors++;
          $display("FAIL reset_clear s%0d cyc%0d: vld=%b dout=%h required vld=%b dout=%h",
                   p, cyc, obs_vld[p], obs_dout[p], exp_vld[p], exp_dout[p]);
        end
      end
      checks++;
      if (obs_busy !== {2{exp_busy}}) begin
        errors++;
        $display("FAIL reset_busy cyc%0d: busy=%b required %b", cyc, obs_busy, {2{exp_busy}});
      end
    end
    checks++;
    if (busy_cnt != 128) begin
      errors++;
      $display("FAIL reset_busy_len: busy cycles=%0d required 128", busy_cnt);
    end
    zero_cnt = 0;
    for (int n = 0; n < int'(Half) + 3; n++) begin
      if (n < int'(Half)) begin
        set_a(1'b1, 1'b0, AW'(2 * n), '0);
        set_b(1'b1, 1'b0, AW'(2 * n + 1), '0);
      end else begin
        set_idle();
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_vld[p] !== exp_vld[p] || obs_dout[p] !== exp_dout[p]) begin
          errors++;
          $display("FAIL reset_readback s%0d cyc%0d: vld=%b dout=%h required vld=%b dout=%h",
                   p, cyc, obs_vld[p], obs_dout[p], exp_vld[p], exp_dout[p]);
        end
        if (obs_vld[p] === 1'b1 && obs_dout[p] === 16'h0000) zero_cnt++;
      end
    end
    checks++;
    if (zero_cnt != 4 * int'(Half)) begin
      errors++;
      $display("FAIL reset_all_zero: zero reads=%0d required %0d", zero_cnt, 4 * Half);
    end
  endtask

  task automatic test_basic();
    set_a(1'b1, 1'b1, 8'h05, 16'h0D01);
    set_b(1'b1, 1'b1, 8'hFF, 16'h0ABC);
    tick();
    set_a(1'b1, 1'b0, 8'hFF, '0);
    set_b(1'b1, 1'b0, 8'h05, '0);
    tick();
    set_idle();
    checks++;
    if (obs_vld !== 4'b0000) begin
      errors++;
      $display("FAIL basic_early cyc%0d: vld=%b required 0000", cyc, obs_vld);
    end
    tick();
    checks++;
    if (obs_vld !== 4'b0011 || obs_dout[0] !== 16'h0ABC || obs_dout[1] !== 16'h0D01) begin
      errors++;
      $display("FAIL basic_lat1 cyc%0d: vld=%b a=%h b=%h required vld=0011 a=0abc b=0d01",
               cyc, obs_vld, obs_dout[0], obs_dout[1]);
    end
    tick();
    checks++;
    if (obs_vld !== 4'b1100 || obs_dout[2] !== 16'h0ABC || obs_dout[3] !== 16'h0D01 ||
        obs_dout[0] !== 16'h0ABC) begin
      errors++;
      $display("FAIL basic_lat2 cyc%0d: vld=%b a1=%h b1=%h a0=%h required vld=1100 0abc 0d01 0abc",
               cyc, obs_vld, obs_dout[2], obs_dout[3], obs_dout[0]);
    end
    tick();
  endtask

  task automatic test_ww_collision();
    set_a(1'b1, 1'b1, 8'h10, 16'h1111);
    set_b(1'b1, 1'b1, 8'h10, 16'h2222);
    tick();
    set_a(1'b1, 1'b0, 8'h10, '0);
    set_b(1'b1, 1'b0, 8'h10, '0);
    tick();
    set_idle();
    tick();
    checks++;
    if (obs_vld[1:0] !== 2'b11 || obs_dout[0] !== 16'h1111 || obs_dout[1] !== 16'h1111) begin
      errors++;
      $display("FAIL ww_collision cyc%0d: vld=%b a=%h b=%h required 11 1111 1111",
               cyc, obs_vld[1:0], obs_dout[0], obs_dout[1]);
    end
    tick();
    checks++;
    if (obs_vld[3:2] !== 2'b11 || obs_dout[2] !== 16'h1111 || obs_dout[3] !== 16'h1111) begin
      errors++;
      $display("FAIL ww_collision_reg cyc%0d: vld=%b a=%h b=%h required 11 1111 1111",
               cyc, obs_vld[3:2], obs_dout[2], obs_dout[3]);
    end
  endtask

  task automatic test_rw_collision();
    set_a(1'b1, 1'b1, 8'h20, 16'h0777);
    set_b(1'b1, 1'b1, 8'h21, 16'h0888);
    tick();
    set_a(1'b1, 1'b1, 8'h20, 16'h0333);
    set_b(1'b1, 1'b0, 8'h20, '0);
    tick();
    set_a(1'b1, 1'b0, 8'h21, '0);
    set_b(1'b1, 1'b1, 8'h21, 16'h0444);
    tick();
    checks++;
    if (obs_vld[1:0] !== 2'b10 || obs_dout[1] !== 16'h0333 || obs_dout[0] !== 16'h1111) begin
      errors++;
      $display("FAIL rw_collision_b cyc%0d: vld=%b a=%h b=%h required 10 1111 0333",
               cyc, obs_vld[1:0], obs_dout[0], obs_dout[1]);
    end
    set_idle();
    tick();
    checks++;
    if (obs_vld[1:0] !== 2'b01 || obs_dout[0] !== 16'h0444 || obs_dout[1] !== 16'h0333) begin
      errors++;
      $display("FAIL rw_collision_a cyc%0d: vld=%b a=%h b=%h required 01 0444 0333",
               cyc, obs_vld[1:0], obs_dout[0], obs_dout[1]);
    end
    tick();
    tick();
  endtask

  task automatic test_clr_inflight();
    set_a(1'b1, 1'b1, 8'h03, 16'h0ABC);
    tick();
    set_a(1'b1, 1'b0, 8'h03, '0);
    bus0.clr_req = 1'b1;
    tick();
    bus0.clr_req = 1'b0;
    for (int n = 0; n < 132; n++) begin
      if (n < 130) set_random(1'b0);
      else set_idle();
      tick();
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_vld[p] !== exp_vld[p] || obs_dout[p] !== exp_dout[p]) begin
          errors++;
          $display("FAIL clr_inflight s%0d cyc%0d: vld=%b dout=%h required vld=%b dout=%h",
                   p, cyc, obs_vld[p], obs_dout[p], exp_vld[p], exp_dout[p]);
        end
      end
      checks++;
      if (obs_busy !== {2{exp_busy}}) begin
        errors++;
        $display("FAIL clr_inflight_busy cyc%0d: busy=%b required %b",
                 cyc, obs_busy, {2{exp_busy}});
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_random(1'($urandom_range(0, 3) != 0));
      bus0.clr_req = ($urandom_range(0, 199) == 0);
      tick();
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_vld[p] !== exp_vld[p] || obs_dout[p] !== exp_dout[p]) begin
          errors++;
          $display("FAIL random s%0d cyc%0d: vld=%b dout=%h required vld=%b dout=%h",
                   p, cyc, obs_vld[p], obs_dout[p], exp_vld[p], exp_dout[p]);
        end
      end
      checks++;
      if (obs_busy !== {2{exp_busy}}) begin
        errors++;
        $display("FAIL random_busy cyc%0d: busy=%b required %b", cyc, obs_busy, {2{exp_busy}});
      end
    end
    set_idle();
    for (int n = 0; n < 132; n++) tick();
  endtask

  task automatic test_throughput();
    int gaps;
    for (int n = 0; n < int'(Depth); n++) begin
      set_a(1'b1, 1'b1, AW'(n), DW'($urandom));
      set_b(1'b0, 1'b0, '0, '0);
      tick();
    end
    gaps = 0;
    for (int n = 0; n < int'(Depth) + 3; n++) begin
      if (n < int'(Depth)) begin
        set_a(1'b1, 1'b0, AW'(n), '0);
        set_b(1'b1, 1'b0, AW'(Depth - 1 - n), '0);
      end else begin
        set_idle();
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_vld[p] !== exp_vld[p] || obs_dout[p] !== exp_dout[p]) begin
          errors++;
          $display("FAIL throughput s%0d cyc%0d: vld=%b dout=%h required vld=%b dout=%h",
                   p, cyc, obs_vld[p], obs_dout[p], exp_vld[p], exp_dout[p]);
        end
      end
      if (n >= 1 && n <= int'(Depth) && obs_vld[1:0] !== 2'b11) gaps++;
      if (n >= 2 && n <= int'(Depth) + 1 && obs_vld[3:2] !== 2'b11) gaps++;
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL throughput_gaps: gap cycles=%0d required 0", gaps);
    end
  endtask

  task automatic test_mid_clear_reset();
    int busy_cnt, zero_cnt;
    bus0.clr_req = 1'b1;
    tick();
    bus0.clr_req = 1'b0;
    for (int n = 0; n < 40; n++) begin
      set_random(1'b0);
      tick();
    end
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    busy_cnt = 0;
    for (int n = 0; n < 130; n++) begin
      if (bus0.busy === 1'b1) busy_cnt++;
      set_a(1'b1, 1'b1, AW'($urandom), DW'($urandom) | 16'h0001);
      set_b(1'b1, 1'b1, AW'($urandom), DW'($urandom) | 16'h0001);
      if (n >= 127) set_idle();
      tick();
      checks++;
      if (obs_busy !== {2{exp_busy}} || obs_vld !== exp_vld) begin
        errors++;
        $display("FAIL midclr_busy cyc%0d: busy=%b vld=%b required busy=%b vld=%b",
                 cyc, obs_busy, obs_vld, {2{exp_busy}}, exp_vld);
      end
    end
    checks++;
    if (busy_cnt != 128) begin
      errors++;
      $display("FAIL midclr_busy_len: busy cycles=%0d required 128", busy_cnt);
    end
    zero_cnt = 0;
    for (int n = 0; n < int'(Half) + 3; n++) begin
      if (n < int'(Half)) begin
        set_a(1'b1, 1'b0, AW'(2 * n + 1), '0);
        set_b(1'b1, 1'b0, AW'(2 * n), '0);
      end else begin
        set_idle();
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_vld[p] !== exp_vld[p] || obs_dout[p] !== exp_dout[p]) begin
          errors++;
          $display("FAIL midclr_readback s%0d cyc%0d: vld=%b dout=%h required vld=%b dout=%h",
                   p, cyc, obs_vld[p], obs_dout[p], exp_vld[p], exp_dout[p]);
        end
        if (obs_vld[p] === 1'b1 && obs_dout[p] === 16'h0000) zero_cnt++;
      end
    end
    checks++;
    if (zero_cnt != 4 * int'(Half)) begin
      errors++;
      $display("FAIL midclr_all_zero: zero reads=%0d required %0d", zero_cnt, 4 * Half);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(Depth); i++) mem_m[i] = 16'hDEAD;
    for (int p = 0; p < 4; p++) exp_dout[p] = '0;
    rst = 1'b0;
    set_idle();
    test_reset();
    test_basic();
    test_ww_collision();
    test_rw_collision();
    test_clr_inflight();
    test_random();
    test_throughput();
    test_mid_clear_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
